seg7_monitor: RTL
=================

# seg7_monitor

Receive-side checker for the 7-segment digit stream produced by the team's 1-digit counters. Samples the 7 segment lines and decodes them back to a BCD digit, rejecting glitches with a stability filter. Checks that successive digits advance 0→9→0. Measures the clock-cycle period between digit changes. Sits in test/loopback designs where segment outputs are fed back through a second tile, or where another project's display lines are observed.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 1..15.
- PERIOD_WIDTH, 24: width of the period counter and the `period` output.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- segments  in  7  segment lines, bit0 = a … bit6 = g, active high.
- clear_err  in  1  synchronous clear of error flags and error count.
- digit  out  4  last accepted valid digit, 0..9.
- digit_valid  out  1  one-cycle pulse when `digit` updates.
- period  out  PERIOD_WIDTH  cycles between the last two accepted digits.
- period_valid  out  1  one-cycle pulse when `period` updates.
- locked  out  1  high in state TRACK.
- seq_err  out  1  sticky: a digit did not follow (prev+1) mod 10.
- pattern_err  out  1  sticky: a non-blank, non-digit pattern was accepted.
- err_count  out  8  total errors, saturating at 255.

## Operation
- Decode table (hex, a=bit0): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. 00 = blank. Anything else is invalid.
- Stage 1: `segments` registered into `s_q` every cycle.
- Filter: a candidate register and a stability counter.
  - If `s_q` ≠ candidate: load the candidate and set the count to 1.
  - Otherwise increment the count, saturating at STABLE_CYCLES.
  - A pattern is accepted on the cycle the count reaches STABLE_CYCLES while the candidate ≠ `last_pat`.
  - `last_pat` is updated on every acceptance; repeated identical patterns are never re-accepted.
- FSM has two states, ACQUIRE and TRACK. Reset → ACQUIRE.
  - ACQUIRE + valid digit: `digit` updates and `digit_valid` pulses. No sequence check and no `period_valid`. Period counter cleared to 0. → TRACK.
  - TRACK + valid digit: `digit` updates, `digit_valid` pulses, `period_valid` pulses with `period` = counter value + 1. Counter cleared. If the digit ≠ (prev+1) mod 10, set `seq_err` and increment `err_count`. Stay in TRACK.
  - Any state + blank: → ACQUIRE, no error, `digit` holds.
  - Any state + invalid: set `pattern_err`, increment `err_count`, → ACQUIRE, `digit` holds.
- Period counter:
  - Increments every cycle in TRACK.
  - Saturates at all-ones. A saturated counter reports `period` = all-ones; no wrap.
  - In ACQUIRE it is held at 0.
- Errors:
  - `err_count` saturates at 255.
  - `clear_err` zeroes `seq_err`, `pattern_err` and `err_count`.
  - If an error occurs in the same cycle as `clear_err`, the error wins: flag = 1, `err_count` = 1.

## Timing
- Reset values:
  - `digit` = 0, `digit_valid` = 0, `period` = 0, `period_valid` = 0.
  - `locked` = 0, `seq_err` = 0, `pattern_err` = 0, `err_count` = 0.
  - Internally: `last_pat` = 00, candidate = 00, stability count = 0, state ACQUIRE.
- Latency: let E0 be the first edge at which a new stable pattern is present on `segments`. `digit_valid` / `period_valid` / error flags are high in the cycle after edge E0 + STABLE_CYCLES. Example: STABLE_CYCLES = 4 gives 5 edges.
- A pattern held for fewer than STABLE_CYCLES samples is ignored entirely; `last_pat` is unchanged.
- Period: two acceptances that are N edges apart report `period` = N.
- All outputs are registered. Pulses are exactly one cycle wide.
- Reset asserted mid-filter or mid-period: every state returns to its reset value immediately. The first digit after release is handled as in ACQUIRE.

## Test plan
- **Reset and first digit.** Assert reset, then drive 3F held for 10 cycles (STABLE_CYCLES = 4). Required: `digit_valid` 5 edges after the change, `digit` = 0, `locked` = 1, no `period_valid`.
- **Clean count.** Drive 0→1→…→9→0, each digit held 100 cycles. Required: 10 `period_valid` pulses, each with `period` = 100, `seq_err` = 0, `err_count` = 0.
- **Glitch rejection.** While 06 is locked, drive 5B for 3 cycles, then 06 again. Required: no `digit_valid`, digit stays 1.
- **Sequence error and clear.** Drive 2 then 5. Required: `seq_err` = 1, `err_count` = 1, `digit` = 5, `period_valid` pulses. Then pulse `clear_err` → all flags 0.
- **Invalid and blank patterns.** Drive 49 (invalid) → `pattern_err` = 1, `locked` = 0. Drive 00 → no error, `locked` = 0. Drive 3F → ACQUIRE path, no `period_valid`.
- **Saturation and corner cases.** With PERIOD_WIDTH = 8, hold digit 3 for 300 cycles then drive 4 → `period` = FF. Force 260 errors → `err_count` = FF. An error in the same cycle as `clear_err` → `err_count` = 1.

Source files
------------

// File: rtl/seg7_monitor_if.sv
// Segment-stream monitor bundle: sampled segment lines and clear in, decoded digit/period/errors out.
// No handshake; outputs are registered pulses and levels owned by the monitor.
interface seg7_monitor_if #(
  parameter int PERIOD_WIDTH = 24
);
  logic [6:0]              segments;
  logic                    clear_err;
  logic [3:0]              digit;
  logic                    digit_valid;
  logic [PERIOD_WIDTH-1:0] period;
  logic                    period_valid;
  logic                    locked;
  logic                    seq_err;
  logic                    pattern_err;
  logic [7:0]              err_count;

  modport master (
    output segments, clear_err,
    input  digit, digit_valid, period, period_valid, locked, seq_err, pattern_err, err_count
  );

  modport slave (
    input  segments, clear_err,
    output digit, digit_valid, period, period_valid, locked, seq_err, pattern_err, err_count
  );
endinterface

// File: rtl/seg7_monitor.sv
// Decodes a 7-segment stream back to BCD with a stability filter, checks 0..9 sequencing, measures period.
// Latency: outputs register STABLE_CYCLES+1 edges after a new pattern appears; no backpressure (passive observer).
module seg7_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_WIDTH  = 24
) (
  input  logic          clk,
  input  logic          reset,
  seg7_monitor_if.slave mon
);
  typedef enum logic {ACQUIRE, TRACK} state_t;

  localparam logic [3:0]              STABLE     = 4'(STABLE_CYCLES);
  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = '1;

  state_t                  state;
  logic [6:0]              s_q;
  logic [6:0]              cand;
  logic [6:0]              last_pat;
  logic [3:0]              stab_cnt;
  logic [3:0]              stab_next;
  logic [PERIOD_WIDTH-1:0] per_cnt;
  logic                    accept;
  logic                    dec_ok;
  logic                    dec_blank;
  logic [3:0]              dec_digit;
  logic [3:0]              digit_succ;
  logic                    err_seq;
  logic                    err_pat;

  always_comb begin
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    dec_digit = 4'd0;
    case (s_q)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      7'h00: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Acceptance is judged on the count value about to be stored, so the
  // outputs land on the same edge at which the count reaches STABLE.
  always_comb begin
    if (s_q != cand) begin
      stab_next = 4'd1;
    end else if (stab_cnt == STABLE) begin
      stab_next = STABLE;
    end else begin
      stab_next = stab_cnt + 4'd1;
    end
    accept     = (stab_next == STABLE) && (s_q != last_pat);
    digit_succ = (mon.digit == 4'd9) ? 4'd0 : mon.digit + 4'd1;
    err_seq    = accept && dec_ok && (state == TRACK) && (dec_digit != digit_succ);
    err_pat    = accept && !dec_ok && !dec_blank;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ACQUIRE;
      s_q              <= '0;
      cand             <= '0;
      last_pat         <= '0;
      stab_cnt         <= '0;
      per_cnt          <= '0;
      mon.digit        <= '0;
      mon.digit_valid  <= 1'b0;
      mon.period       <= '0;
      mon.period_valid <= 1'b0;
      mon.locked       <= 1'b0;
      mon.seq_err      <= 1'b0;
      mon.pattern_err  <= 1'b0;
      mon.err_count    <= '0;
    end else begin
      s_q              <= mon.segments;
      cand             <= s_q;
      stab_cnt         <= stab_next;
      mon.digit_valid  <= 1'b0;
      mon.period_valid <= 1'b0;

      if (state == TRACK) begin
        if (per_cnt != PERIOD_MAX) per_cnt <= per_cnt + 1'b1;
      end else begin
        per_cnt <= '0;
      end

      if (accept) begin
        last_pat <= s_q;
        per_cnt  <= '0;
        if (dec_ok) begin
          mon.digit       <= dec_digit;
          mon.digit_valid <= 1'b1;
          state           <= TRACK;
          mon.locked      <= 1'b1;
          if (state == TRACK) begin
            mon.period_valid <= 1'b1;
            mon.period       <= (per_cnt == PERIOD_MAX) ? PERIOD_MAX : per_cnt + 1'b1;
          end
        end else begin
          state      <= ACQUIRE;
          mon.locked <= 1'b0;
        end
      end

      // A fault in the clearing cycle still registers, counted from zero.
      if (mon.clear_err) begin
        mon.seq_err     <= 1'b0;
        mon.pattern_err <= 1'b0;
        mon.err_count   <= '0;
      end
      if (err_seq) mon.seq_err <= 1'b1;
      if (err_pat) mon.pattern_err <= 1'b1;
      if (err_seq || err_pat) begin
        if (mon.clear_err) begin
          mon.err_count <= 8'd1;
        end else if (mon.err_count != 8'hFF) begin
          mon.err_count <= mon.err_count + 8'd1;
        end
      end
    end
  end
endmodule
